instr_decode: RTL and testbench
===============================

INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter MUL_WAIT, default 2: cycles instr_ready is held low after a multiply issues (0 = no hold).
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_in  in  16  instruction word.
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  decoder accepts instr_in this cycle.
- dec_valid  out  1  decoded fields are valid.
- dec_ready  in  1  execute stage consumes the decoded fields.
- opco  out  4  ALU opcode.
- funct  out  3  ALU function.
- shamtt  out  3  shift amount.
- rs_addr  out  3  source register address.
- rt_addr  out  3  second source register address.
- rd_addr  out  3  destination register address.
- constant_out  out  16  sign-extended immediate.
- constant_en  out  1  ALU selects constant_out over rt.
- reg_we  out  1  register-file write enable.
- hilo_we  out  1  hi/lo write enable.
- illegal  out  1  decoded opcode is undefined.
- trap  out  1  held trap.
- trap_clr  in  1  releases trap.

Function
REQ-003 SHALL take opco = instr_in[15:12] and rs_addr = [11:9] for every format.
REQ-004 R-format (op 0,3,4,10) SHALL decode rt=[8:6], rd=[5:3], funct=[2:0], constant_en=0.
- reg_we=1 for op 0,3,4; reg_we=0 for op 10.
- op 10 SHALL set hilo_we=1.
REQ-005 S-format (op 1,2) SHALL decode rd=[8:6], shamtt=[5:3], rt=0, reg_we=1.
REQ-006 I-format (op 5,7,8) SHALL decode:
- rd=[8:6];
- constant_out = [5:0] sign-extended to 16 bits;
- constant_en=1;
- reg_we=1 for op 5,7; reg_we=0 for op 8.
REQ-007 Any other opcode SHALL set illegal=1 with reg_we=0 and hilo_we=0; fields not defined for a format SHALL output 0.
REQ-008 The FSM SHALL have states EMPTY, FULL, MUL_HOLD and TRAP; it resets to EMPTY.
REQ-009 instr_ready SHALL equal (state==EMPTY) or (state==FULL and dec_ready).
REQ-010 Transfers and latency:
- An accept (instr_valid and instr_ready) SHALL register the decoded fields and give dec_valid=1 on the next cycle (1-cycle latency).
- Back-to-back accepts SHALL sustain 1 instruction per cycle.
REQ-011 While dec_valid=1 and dec_ready=0, all outputs SHALL hold stable; dec_valid SHALL stay 1.
REQ-012 Output consumed with no new accept SHALL give dec_valid=0 and state EMPTY next cycle.
REQ-013 Consumption of an entry with hilo_we=1 SHALL enter MUL_HOLD with counter=MUL_WAIT.
- instr_ready=0 in MUL_HOLD; counter decrements each cycle; exit to EMPTY when counter reaches 0.
- MUL_WAIT=0 SHALL bypass MUL_HOLD.
REQ-014 Simultaneous consume of a multiply and an offered new instruction: the new instruction SHALL NOT be accepted.

Reset
REQ-015 rst SHALL, in the same cycle as the clock edge it is sampled on, force:
- state EMPTY and MUL_HOLD counter 0;
- dec_valid=0 and trap=0;
- all decoded outputs 0.
This applies mid-hold and mid-trap; an in-flight instruction SHALL be discarded.

Configuration
REQ-016 Macro ILLEGAL_TRAP_EN:
- Defined: when an illegal entry is consumed, the FSM SHALL enter TRAP with trap=1 and instr_ready=0 until trap_clr=1, then go to EMPTY.
- Undefined: illegal entries SHALL pass as NOPs; trap SHALL be tied 0 and trap_clr ignored.

Structure
REQ-017 A shared package SHALL hold:
- opcode constants (OP_RTYPE=0, OP_SLL=1, OP_SRL=2, OP_OR=3, OP_AND=4, OP_ADDI=5, OP_LOAD=7, OP_STORE=8, OP_MULT=10);
- the state enum;
- the decoded-field struct.
REQ-018 The combinational field decode SHALL be one sub-module, instr_field_dec; the FSM, handshake and output register SHALL stay in the top module.

Verification
REQ-019 Directed scenarios, one line each:
- 0x0298 with dec_ready=1 -> next cycle opco=0, rs=1, rt=2, rd=3, funct=0, reg_we=1, constant_en=0.
- 0x52BF -> opco=5, rs=1, rd=2, constant_out=0xFFFF, constant_en=1; then 0x1958 back-to-back -> opco=1, rs=4, rd=5, shamtt=3, one per cycle.
- 0xA280 consumed with MUL_WAIT=2 -> hilo_we=1, reg_we=0; instr_ready low exactly 2 cycles, then high.
- dec_ready=0 for 3 cycles with a valid entry -> outputs stable, instr_ready=0; the next instruction is not lost.
- 0xF000 -> illegal=1; with ILLEGAL_TRAP_EN, trap=1 until a trap_clr pulse; without it, a NOP passes and instr_ready=1.
- rst asserted during MUL_HOLD -> next cycle dec_valid=0, instr_ready=1, trap=0.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared types for the 16-bit instruction decoder:
// opcode constants, FSM state enum, decoded-field bundle.
package instr_decode_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_SLL   = 4'd1;
  localparam logic [3:0] OP_SRL   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;
  localparam logic [3:0] OP_MULT  = 4'd10;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    MUL_HOLD,
    TRAP
  } state_t;

  typedef struct packed {
    logic [3:0]  opco;
    logic [2:0]  funct;
    logic [2:0]  shamtt;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [2:0]  rd_addr;
    logic [15:0] constant_out;
    logic        constant_en;
    logic        reg_we;
    logic        hilo_we;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/instr_decode_field_dec.sv
// Combinational field decode of one 16-bit instruction word.
// Ports: instr (word in), dec (decoded field bundle out).
module instr_field_dec
  import instr_decode_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  logic [3:0] op;
  logic       is_r;
  logic       is_s;
  logic       is_i;

  assign op   = instr[15:12];
  assign is_r = (op == OP_RTYPE) || (op == OP_OR)
             || (op == OP_AND) || (op == OP_MULT);
  assign is_s = (op == OP_SLL) || (op == OP_SRL);
  assign is_i = (op == OP_ADDI) || (op == OP_LOAD)
             || (op == OP_STORE);

  always_comb begin
    dec         = '0;
    dec.opco    = op;
    dec.rs_addr = instr[11:9];
    unique case (1'b1)
      is_r: begin
        dec.rt_addr = instr[8:6];
        dec.rd_addr = instr[5:3];
        dec.funct   = instr[2:0];
        dec.reg_we  = (op != OP_MULT);
        dec.hilo_we = (op == OP_MULT);
      end
      is_s: begin
        dec.rd_addr = instr[8:6];
        dec.shamtt  = instr[5:3];
        dec.reg_we  = 1'b1;
      end
      is_i: begin
        dec.rd_addr      = instr[8:6];
        dec.constant_out = {{10{instr[5]}}, instr[5:0]};
        dec.constant_en  = 1'b1;
        dec.reg_we       = (op != OP_STORE);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// Registered instruction decoder with valid/ready handshake, multiply
// hold-off and optional illegal-opcode trap (macro ILLEGAL_TRAP_EN).
// Ports: clk, rst (sync, active-high), instr_in/instr_valid/instr_ready
// upstream; dec_valid/dec_ready plus decoded fields downstream;
// trap/trap_clr for the held trap.
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int MUL_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [3:0]  opco,
  output logic [2:0]  funct,
  output logic [2:0]  shamtt,
  output logic [2:0]  rs_addr,
  output logic [2:0]  rt_addr,
  output logic [2:0]  rd_addr,
  output logic [15:0] constant_out,
  output logic        constant_en,
  output logic        reg_we,
  output logic        hilo_we,
  output logic        illegal,
  output logic        trap,
  input  logic        trap_clr
);

  localparam int CW = (MUL_WAIT < 2) ? 1 : $clog2(MUL_WAIT + 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  dec_t          d;
  dec_t          q;
  logic          consume;
  logic          accept;
  logic          mul_blk;
  logic          trap_blk;
  logic          trap_go;

  instr_field_dec u_field_dec (
    .instr (instr_in),
    .dec   (d)
  );

`ifdef ILLEGAL_TRAP_EN
  assign trap_blk = q.illegal;
  assign trap_go  = trap_clr;
  assign trap     = (state == TRAP);
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap_blk = 1'b0;
  assign trap_go  = 1'b1;
  assign trap     = 1'b0;
`endif

  // Retiring a multiply or trapping entry must not let a new
  // instruction slip in alongside it.
  assign mul_blk     = q.hilo_we && (MUL_WAIT != 0);
  assign consume     = (state == FULL) && dec_ready;
  assign instr_ready = (state == EMPTY)
                    || (consume && !mul_blk && !trap_blk);
  assign accept      = instr_valid && instr_ready;
  assign dec_valid   = (state == FULL);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL: begin
        if (consume) begin
          if (mul_blk) begin
            state_nx = MUL_HOLD;
            cnt_nx   = CW'(MUL_WAIT);
          end else if (trap_blk) begin
            state_nx = TRAP;
          end else if (accept) begin
            state_nx = FULL;
          end else begin
            state_nx = EMPTY;
          end
        end
      end
      MUL_HOLD: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CW'(1)) begin
          state_nx = EMPTY;
          cnt_nx   = '0;
        end
      end
      TRAP: if (trap_go) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) q <= d;
    end
  end

  assign opco         = q.opco;
  assign funct        = q.funct;
  assign shamtt       = q.shamtt;
  assign rs_addr      = q.rs_addr;
  assign rt_addr      = q.rt_addr;
  assign rd_addr      = q.rd_addr;
  assign constant_out = q.constant_out;
  assign constant_en  = q.constant_en;
  assign reg_we       = q.reg_we;
  assign hilo_we      = q.hilo_we;
  assign illegal      = q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: decode table, directed
// handshake corners, and randomized traffic against a queue model.
module tb_instr_decode;

  localparam int MW = 2;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  opco;
    logic [2:0]  funct;
    logic [2:0]  sh;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] c;
    logic        cen;
    logic        rwe;
    logic        hwe;
    logic        ill;
  } fld_t;

  typedef struct {
    logic [15:0] instr;
    fld_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  opco;
  logic [2:0]  funct;
  logic [2:0]  shamtt;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [2:0]  rd_addr;
  logic [15:0] constant_out;
  logic        constant_en;
  logic        reg_we;
  logic        hilo_we;
  logic        illegal;
  logic        trap;
  logic        trap_clr;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_decode #(.MUL_WAIT(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .opco         (opco),
    .funct        (funct),
    .shamtt       (shamtt),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rd_addr      (rd_addr),
    .constant_out (constant_out),
    .constant_en  (constant_en),
    .reg_we       (reg_we),
    .hilo_we      (hilo_we),
    .illegal      (illegal),
    .trap         (trap),
    .trap_clr     (trap_clr)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic fld_t dut_fld();
    return {opco, funct, shamtt, rs_addr, rt_addr, rd_addr,
            constant_out, constant_en, reg_we, hilo_we, illegal};
  endfunction

  function automatic fld_t mk(int op, int fn, int sh, int rs, int rt,
                              int rd, int c, int cen, int rwe,
                              int hwe, int ill);
    fld_t f;
    f.opco  = 4'(op);
    f.funct = 3'(fn);
    f.sh    = 3'(sh);
    f.rs    = 3'(rs);
    f.rt    = 3'(rt);
    f.rd    = 3'(rd);
    f.c     = 16'(c);
    f.cen   = 1'(cen);
    f.rwe   = 1'(rwe);
    f.hwe   = 1'(hwe);
    f.ill   = 1'(ill);
    return f;
  endfunction

  // Reference decode from the format rules, immediate via integer math.
  function automatic fld_t ref_dec(logic [15:0] w);
    fld_t f;
    int   op;
    int   imm;
    f      = '0;
    op     = int'(w[15:12]);
    f.opco = w[15:12];
    f.rs   = w[11:9];
    if (op inside {0, 3, 4, 10}) begin
      f.rt    = w[8:6];
      f.rd    = w[5:3];
      f.funct = w[2:0];
      f.rwe   = (op != 10);
      f.hwe   = (op == 10);
    end else if (op inside {1, 2}) begin
      f.rd  = w[8:6];
      f.sh  = w[5:3];
      f.rwe = 1'b1;
    end else if (op inside {5, 7, 8}) begin
      f.rd = w[8:6];
      imm  = int'(w[5:0]);
      if (imm > 31) imm = imm - 64;
      f.c   = 16'(imm);
      f.cen = 1'b1;
      f.rwe = (op != 8);
    end else begin
      f.ill = 1'b1;
    end
    return f;
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    instr_valid = 1'b0;
    dec_ready   = 1'b0;
    trap_clr    = 1'b0;
    instr_in    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  fld_t mq[$];
  int   hold;
  bit   trapped;

  initial begin
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{16'h0298, mk(0, 0, 0, 1, 2, 3, 0, 0, 1, 0, 0)};
    tbl[1]  = '{16'h52BF, mk(5, 0, 0, 1, 0, 2, 16'hFFFF, 1, 1, 0, 0)};
    tbl[2]  = '{16'h1958, mk(1, 0, 3, 4, 0, 5, 0, 0, 1, 0, 0)};
    tbl[3]  = '{16'hA280, mk(10, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0)};
    tbl[4]  = '{16'hF000, mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[5]  = '{16'h7E1A, mk(7, 0, 0, 7, 0, 0, 16'h001A, 1, 1, 0, 0)};
    tbl[6]  = '{16'h8C25, mk(8, 0, 0, 6, 0, 0, 16'hFFE5, 1, 0, 0, 0)};
    tbl[7]  = '{16'h3FFF, mk(3, 7, 0, 7, 7, 7, 0, 0, 1, 0, 0)};
    tbl[8]  = '{16'h2ABC, mk(2, 0, 7, 5, 0, 2, 0, 0, 1, 0, 0)};
    tbl[9]  = '{16'h4123, mk(4, 3, 0, 0, 4, 4, 0, 0, 1, 0, 0)};
    tbl[10] = '{16'h6FFF, mk(6, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{16'h9FFF, mk(9, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1)};

    // reset state
    do_reset();
    chk("rst_vld", dec_valid, 0);
    chk("rst_rdy", instr_ready, 1);
    chk("rst_trap", trap, 0);
    chk("rst_fld", dut_fld(), 0);

    // decode table
    for (int i = 0; i < 12; i++) begin
      int n = 0;
      while (!instr_ready && n < 20) begin
        trap_clr = 1'b1;
        tick();
        n++;
      end
      trap_clr = 1'b0;
      chk("tbl_rdy", instr_ready, 1);
      instr_in    = tbl[i].instr;
      instr_valid = 1'b1;
      dec_ready   = 1'b0;
      tick();
      chk("tbl_vld", dec_valid, 1);
      chk("tbl_fld", dut_fld(), tbl[i].exp);
      instr_valid = 1'b0;
      dec_ready   = 1'b1;
      tick();
      dec_ready = 1'b0;
    end

    // back-to-back
    do_reset();
    instr_in    = 16'h52BF;
    instr_valid = 1'b1;
    dec_ready   = 1'b1;
    #1 chk("b2b_rdy0", instr_ready, 1);
    tick();
    chk("b2b_vld0", dec_valid, 1);
    chk("b2b_fld0", dut_fld(), ref_dec(16'h52BF));
    instr_in = 16'h1958;
    #1 chk("b2b_rdy1", instr_ready, 1);
    tick();
    chk("b2b_vld1", dec_valid, 1);
    chk("b2b_fld1", dut_fld(), ref_dec(16'h1958));
    instr_valid = 1'b0;
    tick();
    chk("b2b_drain", dec_valid, 0);

    // multiply hold-off
    do_reset();
    instr_in    = 16'hA280;
    instr_valid = 1'b1;
    tick();
    chk("mul_hwe", hilo_we, 1);
    chk("mul_rwe", reg_we, 0);
    instr_in  = 16'h0298;
    dec_ready = 1'b1;
    #1 chk("mul_cons_rdy", instr_ready, 0);
    tick();
    chk("mul_vld", dec_valid, 0);
    chk("mul_h1", instr_ready, 0);
    tick();
    chk("mul_h2", instr_ready, 0);
    tick();
    chk("mul_rel", instr_ready, 1);
    tick();
    chk("mul_next_vld", dec_valid, 1);
    chk("mul_next_fld", dut_fld(), ref_dec(16'h0298));
    instr_valid = 1'b0;
    tick();

    // downstream stall
    do_reset();
    instr_in    = 16'h3FFF;
    instr_valid = 1'b1;
    tick();
    instr_in = 16'h4123;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_rdy", instr_ready, 0);
      tick();
      chk("stall_vld", dec_valid, 1);
      chk("stall_fld", dut_fld(), ref_dec(16'h3FFF));
    end
    dec_ready = 1'b1;
    #1 chk("stall_rel", instr_ready, 1);
    tick();
    chk("stall_nvld", dec_valid, 1);
    chk("stall_nfld", dut_fld(), ref_dec(16'h4123));
    instr_valid = 1'b0;
    tick();

    // illegal opcode
    do_reset();
    instr_in    = 16'hF000;
    instr_valid = 1'b1;
    tick();
    chk("ill_flag", illegal, 1);
    instr_valid = 1'b0;
    dec_ready   = 1'b1;
    if (TRAP_EN) begin
      #1 chk("trap_cons_rdy", instr_ready, 0);
      tick();
      chk("trap_set", trap, 1);
      chk("trap_rdy", instr_ready, 0);
      tick();
      chk("trap_hold", trap, 1);
      trap_clr = 1'b1;
      tick();
      trap_clr = 1'b0;
      chk("trap_clr", trap, 0);
      chk("trap_clr_rdy", instr_ready, 1);
    end else begin
      #1 chk("nop_cons_rdy", instr_ready, 1);
      tick();
      chk("nop_trap", trap, 0);
      chk("nop_rdy", instr_ready, 1);
      chk("nop_vld", dec_valid, 0);
    end

    // reset during multiply hold
    do_reset();
    instr_in    = 16'hA280;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    dec_ready   = 1'b1;
    tick();
    chk("rsth_pre", instr_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsth_vld", dec_valid, 0);
    chk("rsth_rdy", instr_ready, 1);
    chk("rsth_trap", trap, 0);
    chk("rsth_fld", dut_fld(), 0);

    // randomized traffic vs queue model
    do_reset();
    mq.delete();
    hold    = 0;
    trapped = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit   blk;
      bit   exp_rdy;
      bit   acc;
      fld_t nd;
      fld_t e;
      logic [31:0] r;
      r           = $urandom;
      instr_in    = {4'($urandom_range(0, 15)), r[11:0]};
      instr_valid = ($urandom_range(0, 3) != 0);
      dec_ready   = ($urandom_range(0, 3) != 0);
      trap_clr    = ($urandom_range(0, 7) == 0);
      blk = 1'b0;
      if (mq.size() > 0)
        blk = (mq[0].hwe && MW > 0) || (mq[0].ill && TRAP_EN);
      exp_rdy = !trapped && hold == 0 &&
                (mq.size() == 0 || (dec_ready && !blk));
      #1 chk("rnd_rdy", instr_ready, exp_rdy);
      acc = instr_valid && exp_rdy;
      nd  = ref_dec(instr_in);
      tick();
      if (mq.size() > 0 && dec_ready) begin
        e = mq.pop_front();
        if (e.hwe && MW > 0) hold = MW;
        else if (e.ill && TRAP_EN) trapped = 1'b1;
      end else if (hold > 0) begin
        hold--;
      end else if (trapped && trap_clr) begin
        trapped = 1'b0;
      end
      if (acc) mq.push_back(nd);
      chk("rnd_vld", dec_valid, mq.size() > 0);
      if (mq.size() > 0) chk("rnd_fld", dut_fld(), mq[0]);
      chk("rnd_trap", trap, trapped);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
